// File: rtl/alu_isa_pkg.sv
// ALU ISA constants shared by the instruction encoder and the control decoder.
// Holds the op enum, opcode/func values, field positions and the pack helper.
package alu_isa_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_SLL  = 3'd4,
        OP_SRL  = 3'd5,
        OP_ADDI = 3'd6,
        OP_ILL  = 3'd7
    } alu_op_e;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ITYPE = 6'b111111;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;

    localparam int OPC_LSB = 26;
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;
    localparam int SH_LSB  = 6;

    function automatic logic [31:0] rtype(
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [4:0] rd,
        input logic [4:0] sh,
        input logic [5:0] fn
    );
        logic [31:0] w;
        w = '0;
        w[OPC_LSB +: 6] = OPC_RTYPE;
        w[RS_LSB  +: 5] = rs;
        w[RT_LSB  +: 5] = rt;
        w[RD_LSB  +: 5] = rd;
        w[SH_LSB  +: 5] = sh;
        w[5:0]          = fn;
        return w;
    endfunction

    function automatic logic [31:0] pack_instr(
        input alu_op_e     op,
        input logic [4:0]  rd,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [15:0] imm
    );
        logic [31:0] w;
        w = '0;
        unique case (op)
            OP_ADD:  w = rtype(rs, rt, rd, 5'd0, F_ADD);
            OP_SUB:  w = rtype(rs, rt, rd, 5'd0, F_SUB);
            OP_AND:  w = rtype(rs, rt, rd, 5'd0, F_AND);
            OP_OR:   w = rtype(rs, rt, rd, 5'd0, F_OR);
            // shifts take their source in the rt slot, rs is zero
            OP_SLL:  w = rtype(5'd0, rs, rd, imm[4:0], F_SLL);
            OP_SRL:  w = rtype(5'd0, rs, rd, imm[4:0], F_SRL);
            OP_ADDI: begin
                w[OPC_LSB +: 6] = OPC_ITYPE;
                w[RS_LSB  +: 5] = rs;
                w[RT_LSB  +: 5] = rd;
                w[15:0]         = imm;
            end
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with valid/ready on both sides and an occupancy output.
// The head word is read straight from the storage registers.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [LW-1:0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          push;
    logic          pop;

    assign in_ready  = (count != LW'(DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign level     = count;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs symbolic ALU requests into 32-bit words and queues them for issue.
// Illegal ops are swallowed and raise a sticky error flag.
module instr_encoder
    import alu_isa_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [2:0]               req_op,
    input  logic [4:0]               req_rd,
    input  logic [4:0]               req_rs,
    input  logic [4:0]               req_rt,
    input  logic [15:0]              req_imm,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [31:0]              instr,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         issued_cnt,
    output logic                     err_illegal
);

    alu_op_e     op;
    logic        legal;
    logic        fifo_ready;
    logic [31:0] word;

    assign op        = alu_op_e'(req_op);
    assign legal     = (op != OP_ILL);
    assign word      = pack_instr(op, req_rd, req_rs, req_rt, req_imm);
    assign req_ready = fifo_ready;

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (req_valid & legal),
        .in_ready  (fifo_ready),
        .in_data   (word),
        .out_valid (instr_valid),
        .out_ready (instr_ready),
        .out_data  (instr),
        .level     (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_cnt  <= '0;
            err_illegal <= 1'b0;
        end else begin
            if (instr_valid && instr_ready)
                issued_cnt <= issued_cnt + CNT_W'(1);
            if (req_valid && req_ready && !legal)
                err_illegal <= 1'b1;
        end
    end

endmodule
